// File: rtl/nand_truth_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nand_truth_sequencer
// Brief    : Sweeps {A,B} through 00,01,10,11 and checks the gate output Q
//            against the EXPECT truth table. Optional: NANDSEQ_STOP_ON_ERR_EN.
// Revision : 1.0
// ============================================================================
module nand_truth_sequencer #(
    parameter int         HOLD_CYCLES = 20,
    parameter logic [3:0] EXPECT      = 4'b0111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       Q,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_mask
);

    localparam int            CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] c_RELOAD = CW'(HOLD_CYCLES - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    r_vec;
    logic [CW-1:0] r_cnt;

    logic          w_miss;
    logic [3:0]    w_mask_next;
    logic [2:0]    w_count_next;
    logic          w_finish;

    // X/Z on Q must register as a mismatch, hence case-inequality.
    assign w_miss       = (Q !== EXPECT[r_vec]);
    assign w_mask_next  = err_mask | (4'(w_miss) << r_vec);
    assign w_count_next = err_count + 3'(w_miss);

`ifdef NANDSEQ_STOP_ON_ERR_EN
    assign w_finish = w_miss || (r_vec == 2'd3);
`else
    assign w_finish = (r_vec == 2'd3);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_vec     <= 2'd0;
            r_cnt     <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            err_mask  <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state   <= c_DRIVE;
                        r_vec     <= 2'd0;
                        r_cnt     <= c_RELOAD;
                        A         <= 1'b0;
                        B         <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= 3'd0;
                        err_mask  <= 4'd0;
                    end
                end
                c_DRIVE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        err_count <= w_count_next;
                        err_mask  <= w_mask_next;
                        if (w_finish) begin
                            r_state <= c_DONE;
                            A       <= 1'b0;
                            B       <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (w_count_next == 3'd0);
                        end else begin
                            r_vec    <= r_vec + 2'd1;
                            {A, B}   <= r_vec + 2'd1;
                            r_cnt    <= c_RELOAD;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
